// File: rtl/bias_add_21.sv
// Layer-21 bias stage: loads KERN_S per-channel biases each frame, then adds them
// with saturation to the channel-interleaved accumulator stream.
module bias_add_21 #(
   parameter int KERN_S      = 16,
   parameter int N_PIX       = 64,
   parameter int COEFF_WIDTH = 16,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [COEFF_WIDTH-1:0] bias_V_dout,
   input  logic                   bias_V_empty_n,
   output logic                   bias_V_read,
   input  logic [ACC_WIDTH-1:0]   acc_V_dout,
   input  logic                   acc_V_empty_n,
   output logic                   acc_V_read,
   output logic [ACC_WIDTH-1:0]   output_V_din,
   input  logic                   output_V_full_n,
   output logic                   output_V_write,
   output logic                   frame_done
);

   localparam int CH_W  = (KERN_S > 1) ? $clog2(KERN_S) : 1;
   localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam int SUM_W = ACC_WIDTH + 1;

   localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {
      S_LOAD,
      S_RUN
   } state_t;

   state_t                 state_q, state_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [PIX_W-1:0]       pix_q, pix_d;
   logic                   out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
   logic                   frame_done_q, frame_done_d;
   logic [COEFF_WIDTH-1:0] bank_q [KERN_S];

   logic                   bias_pop;
   logic                   acc_pop;
   logic                   out_wr;
   logic                   last_ch;
   logic                   last_pix;
   logic [SUM_W-1:0]       sum;
   logic [ACC_WIDTH-1:0]   sum_sat;

   // Strobes are gated by reset so nothing is popped while the block is held in reset.
   assign bias_pop = ap_rst_n && (state_q == S_LOAD) && bias_V_empty_n;
   assign acc_pop  = ap_rst_n && (state_q == S_RUN) && acc_V_empty_n
                     && (!out_valid_q || output_V_full_n);
   assign out_wr   = out_valid_q && output_V_full_n;

   assign last_ch  = (ch_q == CH_W'(KERN_S - 1));
   assign last_pix = (pix_q == PIX_W'(N_PIX - 1));

   assign sum = {acc_V_dout[ACC_WIDTH-1], acc_V_dout}
              + {{(SUM_W-COEFF_WIDTH){bank_q[ch_q][COEFF_WIDTH-1]}}, bank_q[ch_q]};

   // The two top bits of the widened sum differ exactly when the result left the ACC_WIDTH range.
   always_comb begin
      sum_sat = sum[ACC_WIDTH-1:0];
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
         sum_sat = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d      = state_q;
      ch_d         = ch_q;
      pix_d        = pix_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      frame_done_d = 1'b0;

      if (out_wr) begin
         out_valid_d = 1'b0;
      end

      if (bias_pop) begin
         if (last_ch) begin
            ch_d    = '0;
            state_d = S_RUN;
         end else begin
            ch_d = ch_q + CH_W'(1);
         end
      end

      if (acc_pop) begin
         out_data_d  = sum_sat;
         out_valid_d = 1'b1;
         if (last_ch) begin
            ch_d = '0;
            if (last_pix) begin
               pix_d        = '0;
               state_d      = S_LOAD;
               frame_done_d = 1'b1;
            end else begin
               pix_d = pix_q + PIX_W'(1);
            end
         end else begin
            ch_d = ch_q + CH_W'(1);
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q      <= S_LOAD;
         ch_q         <= '0;
         pix_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         pix_q        <= pix_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   // NOTE: the bias bank is a small flop array, not a RAM, so it can and must clear on reset.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < KERN_S; i++) begin
            bank_q[i] <= '0;
         end
      end else if (bias_pop) begin
         bank_q[ch_q] <= bias_V_dout;
      end
   end

   assign bias_V_read    = bias_pop;
   assign acc_V_read     = acc_pop;
   assign output_V_write = out_wr;
   assign output_V_din   = out_data_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_bias_add_21.sv
// Directed bench for bias_add_21 with small frames; FIFO models feed the DUT and a
// scoreboard queue holds the expected outputs in order.
module tb_bias_add_21;

   localparam int KS = 4;
   localparam int NP = 2;
   localparam int CW = 16;
   localparam int AW = 32;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic [CW-1:0] bias_V_dout;
   logic          bias_V_empty_n;
   logic          bias_V_read;
   logic [AW-1:0] acc_V_dout;
   logic          acc_V_empty_n;
   logic          acc_V_read;
   logic [AW-1:0] output_V_din;
   logic          output_V_full_n;
   logic          output_V_write;
   logic          frame_done;

   bias_add_21 #(
      .KERN_S     (KS),
      .N_PIX      (NP),
      .COEFF_WIDTH(CW),
      .ACC_WIDTH  (AW)
   ) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .bias_V_dout    (bias_V_dout),
      .bias_V_empty_n (bias_V_empty_n),
      .bias_V_read    (bias_V_read),
      .acc_V_dout     (acc_V_dout),
      .acc_V_empty_n  (acc_V_empty_n),
      .acc_V_read     (acc_V_read),
      .output_V_din   (output_V_din),
      .output_V_full_n(output_V_full_n),
      .output_V_write (output_V_write),
      .frame_done     (frame_done)
   );

   always #5 ap_clk = ~ap_clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] bias_src[$];
   logic [AW-1:0] acc_src[$];
   logic [AW-1:0] exp_q[$];
   int            mb[KS];
   int            acc_idx = 0;
   int            mon_pops = 0;
   int            fd_cnt = 0;
   bit            fd_exp = 0;
   bit            full_en = 1;
   bit            gap_mode = 0;
   bit            b_rd, a_rd;
   int            cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [AW-1:0] sat_add(input longint a, input longint b);
      longint s;
      s = a + b;
      if (s > 64'sd2147483647)       sat_add = 32'h7FFF_FFFF;
      else if (s < -64'sd2147483648) sat_add = 32'h8000_0000;
      else                           sat_add = s[AW-1:0];
   endfunction

   task automatic push_bias(input int b0, input int b1, input int b2, input int b3);
      mb[0] = b0; mb[1] = b1; mb[2] = b2; mb[3] = b3;
      for (int i = 0; i < KS; i++) bias_src.push_back(CW'(mb[i]));
   endtask

   task automatic push_acc(input longint v);
      acc_src.push_back(v[AW-1:0]);
      exp_q.push_back(sat_add(v, longint'(mb[acc_idx % KS])));
      acc_idx++;
   endtask

   task automatic wait_drain(input int budget);
      int g = 0;
      while (exp_q.size() != 0 && g < budget) begin
         @(negedge ap_clk);
         g++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // Counts bias pops, requiring no accumulator pop until all KS biases are in.
   task automatic check_load_phase(input string tag);
      int bp = 0;
      int g  = 0;
      while (bp < KS && g < 200) begin
         @(negedge ap_clk);
         check({tag, "_acc_rd_in_load"}, acc_V_read, 0);
         if (bias_V_read) bp++;
         g++;
      end
      check({tag, "_bias_pops"}, bp, KS);
      @(negedge ap_clk);
      check({tag, "_acc_rd_after_load"}, acc_V_read, 1);
   endtask

   // FIFO models and output monitor: sample at negedge, update sources just after posedge.
   initial begin
      bias_V_dout = '0; bias_V_empty_n = 1'b0;
      acc_V_dout = '0;  acc_V_empty_n = 1'b0;
      output_V_full_n = 1'b1;
      forever begin
         @(negedge ap_clk);
         b_rd = bias_V_read;
         a_rd = acc_V_read;
         if (output_V_write) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $error("FAIL unexpected_write: observed %h expected no write", output_V_din);
            end else begin
               check("output", output_V_din, exp_q.pop_front());
            end
         end
         if (frame_done || fd_exp) check("frame_done", frame_done, fd_exp);
         if (frame_done) fd_cnt++;
         fd_exp = 0;
         if (a_rd) begin
            mon_pops++;
            if (mon_pops == KS * NP) begin
               fd_exp   = 1;
               mon_pops = 0;
            end
         end
         @(posedge ap_clk);
         #1;
         cyc++;
         if (b_rd && bias_src.size() > 0) void'(bias_src.pop_front());
         if (a_rd && acc_src.size() > 0) void'(acc_src.pop_front());
         bias_V_empty_n  = (bias_src.size() > 0) && (!gap_mode || (cyc % 3 == 0));
         bias_V_dout     = (bias_src.size() > 0) ? bias_src[0] : '0;
         acc_V_empty_n   = (acc_src.size() > 0);
         acc_V_dout      = (acc_src.size() > 0) ? acc_src[0] : '0;
         output_V_full_n = full_en;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      bit seen;
      int ap;

      // Reset: biases already waiting, but nothing may be read while held.
      ap_rst_n = 1'b0;
      push_bias(10, -5, 0, 7);
      for (int i = 1; i <= 8; i++) push_acc(i);
      repeat (2) @(negedge ap_clk);
      check("rst_bias_read", bias_V_read, 0);
      check("rst_acc_read", acc_V_read, 0);
      check("rst_out_write", output_V_write, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_out_din", output_V_din, 0);
      @(posedge ap_clk); #2;
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("bias_read_after_rst", bias_V_read, 1);

      // Frame 1: basic add.
      wait_drain(100);
      repeat (2) @(negedge ap_clk);
      check("fd_count_f1", fd_cnt, 1);

      // Frame 2: saturation and exact range limits; frame-3 biases queued behind it.
      push_bias(100, -100, 0, 0);
      push_acc(64'sh7FFF_FFF0);
      push_acc(-64'sh7FFF_FFF0);
      push_acc(5);
      push_acc(-5);
      push_acc(64'sh7FFF_FF9B);
      push_acc(-64'sh7FFF_FF9C);
      push_acc(64'sh7FFF_FFFF);
      push_acc(-64'sh8000_0000);
      push_bias(1, 2, 3, 4);
      g = 0; seen = 0;
      while (!seen && g < 100) begin
         @(negedge ap_clk);
         if (frame_done) seen = 1;
         g++;
      end
      check("fd_wait_f2", seen, 1);
      check("drain_overlap_write", output_V_write, 1);
      check("drain_overlap_bias_rd", bias_V_read, 1);
      wait_drain(100);

      // Frame 3: new biases; backpressure held 5 cycles mid-frame.
      push_acc(100);
      push_acc(200);
      push_acc(300);
      wait_drain(100);
      full_en = 0;
      for (int i = 1; i <= 5; i++) push_acc(-i);
      repeat (2) @(negedge ap_clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_acc_read", acc_V_read, 0);
         check("bp_out_write", output_V_write, 0);
         check("bp_din_stable", output_V_din, exp_q[0]);
         @(negedge ap_clk);
      end
      check("bp_one_pending", acc_src.size(), 4);
      full_en = 1;
      wait_drain(100);

      // Frame 4: biases trickle in one per three cycles with accumulators waiting.
      gap_mode = 1;
      push_bias(-7, 1000, -32768, 32767);
      for (int i = 1; i <= 8; i++) push_acc(i * 10);
      check_load_phase("gap");
      gap_mode = 0;
      wait_drain(100);
      repeat (2) @(negedge ap_clk);
      check("fd_count_f4", fd_cnt, 4);

      // Frame 5: reset after three accumulator pops.
      push_bias(5, 6, 7, 8);
      for (int i = 1; i <= 8; i++) push_acc(i);
      ap = 0; g = 0;
      while (ap < 3 && g < 100) begin
         @(negedge ap_clk);
         if (acc_V_read) ap++;
         g++;
      end
      check("pops_before_rst", ap, 3);
      @(posedge ap_clk); #2;
      ap_rst_n = 1'b0;
      bias_src.delete();
      acc_src.delete();
      exp_q.delete();
      acc_idx  = 0;
      mon_pops = 0;
      fd_exp   = 0;
      #1;
      check("midrst_out_din", output_V_din, 0);
      check("midrst_out_write", output_V_write, 0);
      check("midrst_acc_read", acc_V_read, 0);
      check("midrst_bias_read", bias_V_read, 0);
      check("midrst_frame_done", frame_done, 0);

      // Frame 6: full reload after reset before any accumulator pop.
      push_bias(-1, -2, -3, -4);
      for (int i = 11; i <= 18; i++) push_acc(i);
      repeat (2) @(posedge ap_clk);
      #2;
      ap_rst_n = 1'b1;
      check_load_phase("post_rst");
      wait_drain(100);
      repeat (3) @(negedge ap_clk);
      check("fd_count_total", fd_cnt, 5);
      check("acc_src_empty", acc_src.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bias_add_21.md
# bias_add_21

Consumer end of the layer-21 bias stream. The block reads KERN_S bias coefficients from the ap_fifo stream driven by the bias streamer and latches them into a local register bank. It then adds the per-channel bias to every element of the channel-interleaved convolution accumulator stream, saturating each sum, and writes the result to a downstream ap_fifo. It sits between the layer-21 conv accumulator and the activation stage, and reloads the biases at the start of every frame.

## Interface
- KERN_S, 16: output channels; number of biases per frame (≥2).
- N_PIX, 64: pixels per frame; each pixel carries KERN_S accumulator elements, channel innermost.
- COEFF_WIDTH, 16: bias width, signed.
- ACC_WIDTH, 32: accumulator and output width, signed.
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- bias_V_dout  in  COEFF_WIDTH  bias FIFO data.
- bias_V_empty_n  in  1  bias FIFO has data.
- bias_V_read  out  1  bias FIFO pop.
- acc_V_dout  in  ACC_WIDTH  accumulator FIFO data.
- acc_V_empty_n  in  1  accumulator FIFO has data.
- acc_V_read  out  1  accumulator FIFO pop.
- output_V_din  out  ACC_WIDTH  result data.
- output_V_full_n  in  1  output FIFO has space.
- output_V_write  out  1  output FIFO push.
- frame_done  out  1  one-cycle pulse when the last element of a frame is read.

## Operation
- States: LOAD, RUN. Reset state is LOAD.
- LOAD:
  - bias_V_read = bias_V_empty_n.
  - Each pop stores bias_V_dout into bank[ch], then ch increments.
  - When the pop has ch = KERN_S-1: ch←0 and the FSM goes to RUN.
  - acc_V_read = 0 throughout LOAD.
- RUN:
  - bias_V_read = 0.
  - acc_V_read = acc_V_empty_n & (!out_valid | output_V_full_n).
  - On each pop: out_data ← sat(sext(acc_V_dout) + sext(bank[ch])), out_valid ← 1, ch advances modulo KERN_S.
  - When ch wraps, pix increments.
- End of frame:
  - The pop with ch = KERN_S-1 and pix = N_PIX-1 pulses frame_done.
  - The same pop clears ch and pix to 0 and moves the FSM to LOAD.
- Output register:
  - output_V_write = out_valid & output_V_full_n.
  - out_valid clears on a write with no same-cycle pop.
  - A write and a pop in the same cycle keeps out_valid = 1 and loads the new data.
- Arithmetic:
  - Compute the sum in ACC_WIDTH+1 bits.
  - Result > 2^(ACC_WIDTH-1)-1 clamps to max positive; result < -2^(ACC_WIDTH-1) clamps to min negative.
- Drain during LOAD: the output register continues to drain while in LOAD, so bias reload for the next frame overlaps the drain.
- Reset (asserted at any time, including mid-frame):
  - FSM←LOAD; ch, pix, out_valid, frame_done ← 0; bank[] ← 0; output_V_din ← 0.
  - Partially loaded biases and in-flight data are discarded.

## Timing
- Reset values: bias_V_read, acc_V_read, output_V_write, frame_done = 0; output_V_din = 0. bias_V_read goes high combinationally after reset release if bias_V_empty_n = 1.
- Read strobes are combinational from empty_n, full_n and state. No pop ever occurs when empty_n = 0.
- Bias load takes KERN_S cycles minimum, one bias per cycle when the FIFO is not empty.
- LOAD→RUN: the first accumulator pop occurs the cycle after the last bias pop.
- Latency: acc pop at cycle t → output_V_write possible at t+1.
- Throughput in RUN is one element per cycle while acc_V_empty_n = 1 and output_V_full_n = 1.
- Backpressure:
  - full_n = 0 with out_valid = 1 stalls acc reads.
  - output_V_din is held stable until written.
- frame_done is registered and asserts the cycle after the final pop of the frame.

## Test plan
- Basic add (KERN_S=4, N_PIX=2): biases {10,-5,0,7}, acc stream 1..8 → outputs {11,-3,3,11,15,1,7,15}; frame_done pulses once, one cycle after the 8th pop.
- Saturation (ACC_WIDTH=32): bias 100, acc 0x7FFFFFF0 → output 0x7FFFFFFF; bias -100, acc 0x80000010 → output 0x80000000.
- Backpressure: hold output_V_full_n=0 for 5 cycles mid-frame → exactly one pending element, acc_V_read=0, data stable; after release, order is preserved with no loss or duplication.
- Stalled bias load: biases arrive with empty_n gaps (1 of every 3 cycles) and acc data is already present → acc_V_read stays 0 until the 4th bias pop, then the first output uses bank[0].
- Frame reload: run two frames, with frame-2 biases {1,2,3,4} replacing frame-1 biases → frame-2 outputs use the new biases from the first element; the frame-1 last output drains while LOAD reads bias 0.
- Reset mid-frame: assert ap_rst_n=0 asynchronously after 3 RUN pops → all outputs 0 immediately; after release the block reads 4 new biases before any accumulator pop.
